// File: rtl/fm_pkg.sv
`default_nettype none
// ============================================================================
// Module : fm_pkg
// Brief  : Shared constants and state encoding for the frequency meter.
// Rev    : 1.0 - initial release
// ============================================================================
package fm_pkg;

  localparam int unsigned F_REF_HZ = 100_000_000;
  localparam int          CNT_W    = 32;
  localparam int          DIV_W    = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } fc_state_t;

endpackage
`default_nettype wire

// File: rtl/udiv_iter.sv
`default_nettype none
// ============================================================================
// Module : udiv_iter
// Brief  : 64/32 restoring divider, one quotient bit per cycle, 64 cycles.
// Rev    : 1.0 - initial release
// ============================================================================
module udiv_iter
  import fm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [CNT_W-1:0] rem
);

  localparam int c_cnt_w = $clog2(DIV_W);

  logic [CNT_W-1:0]   r_rem;
  logic [CNT_W-1:0]   r_div;
  logic [DIV_W-1:0]   r_quo;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_busy;
  logic               r_done;

  logic [CNT_W-1:0]   w_rem_in;
  logic [CNT_W-1:0]   w_div_in;
  logic [DIV_W-1:0]   w_quo_in;
  logic [CNT_W:0]     w_trial;
  logic [CNT_W:0]     w_diff;
  logic               w_qbit;

  // The start cycle already performs the first iteration on the fresh operands.
  always_comb begin
    w_rem_in = start ? '0       : r_rem;
    w_quo_in = start ? dividend : r_quo;
    w_div_in = start ? divisor  : r_div;
    w_trial  = {w_rem_in, w_quo_in[DIV_W-1]};
    w_diff   = w_trial - {1'b0, w_div_in};
    w_qbit   = ~w_diff[CNT_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_div  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start || r_busy) begin
        r_rem <= w_qbit ? w_diff[CNT_W-1:0] : w_trial[CNT_W-1:0];
        r_quo <= {w_quo_in[DIV_W-2:0], w_qbit};
        r_div <= w_div_in;
      end
      if (start) begin
        r_busy <= 1'b1;
        r_cnt  <= c_cnt_w'(DIV_W - 1);
      end else if (r_busy) begin
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == c_cnt_w'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done     = r_done;
  assign quotient = r_quo;
  assign rem      = r_rem;

endmodule
`default_nettype wire

// File: rtl/freq_compute.sv
`default_nettype none
// ============================================================================
// Module : freq_compute
// Brief  : Computes round(b * F_REF / a) once per new stable counter pair.
// Rev    : 1.0 - initial release
// ============================================================================
module freq_compute
  import fm_pkg::*;
#(
  parameter int unsigned F_REF  = F_REF_HZ,
  parameter int unsigned SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             safe,
  input  logic [CNT_W-1:0] a,
  input  logic [CNT_W-1:0] b,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             busy,
  output logic             div0,
  output logic             ovf
);

  localparam int                 c_stab_w = $clog2(SETTLE + 1);
  localparam logic [c_stab_w-1:0] c_settle = c_stab_w'(SETTLE);
  localparam logic [DIV_W-1:0]   c_f_ref  = DIV_W'(F_REF);

  logic                r_safe_meta;
  logic                r_safe_s;
  logic [c_stab_w-1:0] r_stab;
  fc_state_t           r_state;
  fc_state_t           w_next;
  logic [CNT_W-1:0]    r_a_cap;
  logic [CNT_W-1:0]    r_b_cap;
  logic [CNT_W-1:0]    r_freq;
  logic                r_freq_valid;
  logic                r_div0;
  logic                r_ovf;

  logic                w_stable;
  logic                w_trigger;
  logic                w_start;
  logic [DIV_W-1:0]    w_dividend;
  logic                w_div_done;
  logic [DIV_W-1:0]    w_quotient;
  logic [CNT_W-1:0]    w_unused_rem;

  assign w_stable   = (r_stab == c_settle);
  assign w_trigger  = (r_state == IDLE) && w_stable && ({a, b} != {r_a_cap, r_b_cap});
  assign w_start    = (r_state == LOAD) && (r_a_cap != '0);
  // Adding a/2 before the floor division rounds half up.
  assign w_dividend = ({{(DIV_W-CNT_W){1'b0}}, r_b_cap} * c_f_ref) + DIV_W'(r_a_cap >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_safe_meta <= 1'b0;
      r_safe_s    <= 1'b0;
      r_stab      <= '0;
    end else begin
      r_safe_meta <= safe;
      r_safe_s    <= r_safe_meta;
      if (!r_safe_s)
        r_stab <= '0;
      else if (!w_stable)
        r_stab <= r_stab + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_cap <= '0;
      r_b_cap <= '0;
    end else begin
      r_state <= w_next;
      // Pair is latched on entry to LOAD so the dividend is ready in that cycle.
      if (w_trigger) begin
        r_a_cap <= a;
        r_b_cap <= b;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_trigger) w_next = LOAD;
      LOAD:    w_next = (r_a_cap == '0) ? DONE : DIV;
      DIV:     if (w_div_done) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_freq       <= '0;
      r_freq_valid <= 1'b0;
      r_div0       <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_freq_valid <= 1'b0;
      if ((r_state == LOAD) && (r_a_cap == '0)) begin
        r_freq       <= '0;
        r_div0       <= 1'b1;
        r_ovf        <= 1'b0;
        r_freq_valid <= 1'b1;
      end else if ((r_state == DIV) && w_div_done) begin
        r_div0       <= 1'b0;
        r_freq_valid <= 1'b1;
        if (w_quotient[DIV_W-1:CNT_W] != '0) begin
          r_freq <= '1;
          r_ovf  <= 1'b1;
        end else begin
          r_freq <= w_quotient[CNT_W-1:0];
          r_ovf  <= 1'b0;
        end
      end
    end
  end

  udiv_iter u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_start),
    .dividend (w_dividend),
    .divisor  (r_a_cap),
    .done     (w_div_done),
    .quotient (w_quotient),
    .rem      (w_unused_rem)
  );

  assign freq       = r_freq;
  assign freq_valid = r_freq_valid;
  assign busy       = (r_state != IDLE);
  assign div0       = r_div0;
  assign ovf        = r_ovf;

endmodule
`default_nettype wire
